// File: rtl/cajero_pkg.sv
// Shared definitions for the cashier controller: FSM state codes,
// transaction type codes and a width helper for counters.
package cajero_pkg;

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_RECIBIENDO_PIN = 3'd1;
    localparam logic [2:0] S_COMPARANDO_PIN = 3'd2;
    localparam logic [2:0] S_TRANSACCION    = 3'd3;
    localparam logic [2:0] S_BLOQUEADO      = 3'd4;

    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

    // Counter width able to hold values 0..n-1, never narrower than 1 bit.
    function automatic int ancho(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cajero_pin_colector.sv
// PIN collector: digit counter, PIN buffer and inactivity timer.
// Ports: i_limpiar clears all state; i_recibir/i_esperar mark the
//        digit-collection and transaction-wait phases; o_pin_listo
//        flags the final digit strobe; o_pin_buf holds the digits
//        (first digit in [3:0]); o_timer_expirado flags the idle
//        cycle that completes the timeout window.
module cajero_pin_colector
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_limpiar,
    input  logic                    i_recibir,
    input  logic                    i_esperar,
    input  logic                    i_digito_stb,
    input  logic [3:0]              i_digito,
    input  logic                    i_trans_stb,
    output logic                    o_pin_listo,
    output logic [4*PIN_DIGITS-1:0] o_pin_buf,
    output logic                    o_timer_expirado
);

    localparam int CNT_W = ancho(PIN_DIGITS);
    localparam int TMR_W = ancho(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ULTIMO  = CNT_W'(PIN_DIGITS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [TMR_W-1:0]        r_timer;
    logic [4*PIN_DIGITS-1:0] r_buf;
    logic                    w_digito_ok;
    logic                    w_actividad;
    logic                    w_activo;

    assign w_digito_ok = i_recibir & i_digito_stb;
    assign w_actividad = w_digito_ok | (i_esperar & i_trans_stb);
    assign w_activo    = i_recibir | i_esperar;

    assign o_pin_listo = w_digito_ok & (r_cnt == ULTIMO);
    assign o_pin_buf   = r_buf;
    // Timer already shows TIMEOUT_CYC-1 quiet cycles; this quiet
    // cycle is the last one allowed.
    assign o_timer_expirado = w_activo & ~w_actividad & (r_timer == TMR_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_timer <= '0;
            r_buf   <= '0;
        end else if (i_limpiar) begin
            r_cnt   <= '0;
            r_timer <= '0;
            r_buf   <= '0;
        end else begin
            if (w_digito_ok) begin
                r_buf[4*int'(r_cnt) +: 4] <= i_digito;
                r_cnt <= o_pin_listo ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_actividad) begin
                r_timer <= '0;
            end else if (w_activo && r_timer != TMR_MAX) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/cajero_param.sv
// Automatic-cashier controller: collects a PIN, checks it, locks after
// MAX_INTENTOS failures and runs one deposit/withdrawal per session.
// Ports: card/keypad/transaction inputs, stored PIN and balance in;
//        registered result pulses, lock level and new balance out.
module cajero_param
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int MONTO_W      = 32,
    parameter int BAL_W        = 64,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    digito_stb,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin_correcto,
    input  logic                    tipo_trans,
    input  logic                    trans_stb,
    input  logic [MONTO_W-1:0]      monto,
    input  logic [BAL_W-1:0]        balance_inicial,
    input  logic                    desbloqueo,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic [BAL_W-1:0]        balance_actualizado,
    output logic                    balance_stb,
    output logic                    entregar_dinero,
    output logic                    fondos_insuficientes,
    output logic                    timeout
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam logic [IW-1:0] LIMITE = IW'(MAX_INTENTOS);
    localparam logic [IW-1:0] AVISO  = IW'(MAX_INTENTOS - 1);

    logic [2:0]              r_estado;
    logic [IW-1:0]           r_intentos;
    logic                    w_recibir;
    logic                    w_esperar;
    logic                    w_limpiar;
    logic                    w_pin_listo;
    logic                    w_expirado;
    logic [4*PIN_DIGITS-1:0] w_pin_buf;
    logic [IW-1:0]           w_intentos_sig;
    logic [BAL_W-1:0]        w_monto_ext;
    logic [BAL_W:0]          w_suma;
    logic [BAL_W-1:0]        w_resta;

    assign w_recibir      = (r_estado == S_RECIBIENDO_PIN);
    assign w_esperar      = (r_estado == S_TRANSACCION);
    // Buffer, counter and timer only live during collection/waiting.
    assign w_limpiar      = ~(w_recibir | w_esperar);
    assign w_intentos_sig = r_intentos + IW'(1);
    assign w_monto_ext    = BAL_W'(monto);
    assign w_suma         = {1'b0, balance_inicial} + {1'b0, w_monto_ext};
    assign w_resta        = balance_inicial - w_monto_ext;

    cajero_pin_colector #(
        .PIN_DIGITS  (PIN_DIGITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_colector (
        .clk              (clk),
        .reset            (reset),
        .i_limpiar        (w_limpiar),
        .i_recibir        (w_recibir),
        .i_esperar        (w_esperar),
        .i_digito_stb     (digito_stb),
        .i_digito         (digito),
        .i_trans_stb      (trans_stb),
        .o_pin_listo      (w_pin_listo),
        .o_pin_buf        (w_pin_buf),
        .o_timer_expirado (w_expirado)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado             <= S_IDLE;
            r_intentos           <= '0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            balance_actualizado  <= '0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            timeout              <= 1'b0;
        end else begin
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            timeout              <= 1'b0;
            case (r_estado)
                S_IDLE: begin
                    if (tarjeta_recibida) begin
                        r_estado <= S_RECIBIENDO_PIN;
                    end
                end
                S_RECIBIENDO_PIN: begin
                    if (!tarjeta_recibida) begin
                        r_estado <= S_IDLE;
                    end else if (w_pin_listo) begin
                        r_estado <= S_COMPARANDO_PIN;
                    end else if (w_expirado) begin
                        timeout  <= 1'b1;
                        r_estado <= S_IDLE;
                    end
                end
                S_COMPARANDO_PIN: begin
                    if (!tarjeta_recibida) begin
                        r_estado <= S_IDLE;
                    end else if (w_pin_buf == pin_correcto) begin
                        r_intentos <= '0;
                        r_estado   <= S_TRANSACCION;
                    end else begin
                        r_intentos <= w_intentos_sig;
                        if (w_intentos_sig == LIMITE) begin
                            bloqueo  <= 1'b1;
                            r_estado <= S_BLOQUEADO;
                        end else begin
                            if (w_intentos_sig == AVISO) begin
                                advertencia <= 1'b1;
                            end else begin
                                pin_incorrecto <= 1'b1;
                            end
                            r_estado <= S_RECIBIENDO_PIN;
                        end
                    end
                end
                S_TRANSACCION: begin
                    if (!tarjeta_recibida) begin
                        r_estado <= S_IDLE;
                    end else if (trans_stb) begin
                        r_estado <= S_IDLE;
                        if (tipo_trans == RETIRO) begin
                            if (w_monto_ext > balance_inicial) begin
                                fondos_insuficientes <= 1'b1;
                            end else begin
                                balance_actualizado <= w_resta;
                                balance_stb         <= 1'b1;
                                entregar_dinero     <= 1'b1;
                            end
                        end else begin
                            // Carry out of the balance width saturates.
                            balance_actualizado <= w_suma[BAL_W] ? '1 : w_suma[BAL_W-1:0];
                            balance_stb         <= 1'b1;
                        end
                    end else if (w_expirado) begin
                        timeout  <= 1'b1;
                        r_estado <= S_IDLE;
                    end
                end
                S_BLOQUEADO: begin
                    if (desbloqueo) begin
                        bloqueo    <= 1'b0;
                        r_intentos <= '0;
                        r_estado   <= S_IDLE;
                    end
                end
                default: r_estado <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cajero_param.sv
// Self-checking bench for cajero_param: directed scenarios followed by
// randomized sessions checked against a behavioural session model.
module tb_cajero_param;

    localparam logic [15:0] PIN = 16'h4321;

    logic        clk = 1'b0;
    logic        reset;
    logic        tarjeta_recibida;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [15:0] pin_correcto;
    logic        tipo_trans;
    logic        trans_stb;
    logic [31:0] monto;
    logic [63:0] balance_inicial;
    logic        desbloqueo;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic [63:0] balance_actualizado;
    logic        balance_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic        timeout;

    int ntests = 0;
    int nfail  = 0;

    // Model of what the user-visible session state should be.
    int          m_int    = 0;
    bit          m_locked = 0;
    logic [63:0] m_bal    = '0;

    cajero_param #(
        .PIN_DIGITS   (4),
        .MAX_INTENTOS (3),
        .MONTO_W      (32),
        .BAL_W        (64),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .pin_correcto         (pin_correcto),
        .tipo_trans           (tipo_trans),
        .trans_stb            (trans_stb),
        .monto                (monto),
        .balance_inicial      (balance_inicial),
        .desbloqueo           (desbloqueo),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .balance_actualizado  (balance_actualizado),
        .balance_stb          (balance_stb),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .timeout              (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit pi, input bit adv,
                              input bit blq, input bit bstb, input bit ent,
                              input bit fond, input bit to,
                              input logic [63:0] bal);
        chk({tag, ".pin_incorrecto"}, 64'(pin_incorrecto), 64'(pi));
        chk({tag, ".advertencia"}, 64'(advertencia), 64'(adv));
        chk({tag, ".bloqueo"}, 64'(bloqueo), 64'(blq));
        chk({tag, ".balance_stb"}, 64'(balance_stb), 64'(bstb));
        chk({tag, ".entregar"}, 64'(entregar_dinero), 64'(ent));
        chk({tag, ".fondos"}, 64'(fondos_insuficientes), 64'(fond));
        chk({tag, ".timeout"}, 64'(timeout), 64'(to));
        chk({tag, ".balance"}, balance_actualizado, bal);
    endtask

    task automatic quiet(input string tag);
        check_outs(tag, 0, 0, m_locked, 0, 0, 0, 0, m_bal);
    endtask

    task automatic send_digit(input logic [3:0] d);
        digito     = d;
        digito_stb = 1'b1;
        step();
        digito_stb = 1'b0;
    endtask

    task automatic insert();
        tarjeta_recibida = 1'b1;
        step();
    endtask

    task automatic remove_card();
        tarjeta_recibida = 1'b0;
        step();
        step();
    endtask

    // Enters four digits, digit k taken from entered[4k+3:4k], then
    // checks the verdict two cycles after the last strobe.
    task automatic try_pin(input logic [15:0] entered, input string tag);
        bit pi;
        bit adv;
        pi  = 0;
        adv = 0;
        for (int k = 0; k < 4; k++) send_digit(entered[4*k +: 4]);
        quiet({tag, ".cmp"});
        step();
        if (entered == PIN) begin
            m_int = 0;
        end else begin
            m_int++;
            if (m_int >= 3)      m_locked = 1;
            else if (m_int == 2) adv = 1;
            else                 pi = 1;
        end
        check_outs(tag, pi, adv, m_locked, 0, 0, 0, 0, m_bal);
    endtask

    task automatic do_trans(input bit tipo, input logic [31:0] m,
                            input logic [63:0] b, input string tag);
        logic [64:0] s;
        bit bstb;
        bit ent;
        bit fond;
        bstb = 0;
        ent  = 0;
        fond = 0;
        tipo_trans      = tipo;
        monto           = m;
        balance_inicial = b;
        trans_stb       = 1'b1;
        step();
        trans_stb = 1'b0;
        if (tipo) begin
            if ({32'b0, m} > b) begin
                fond = 1;
            end else begin
                m_bal = b - {32'b0, m};
                bstb  = 1;
                ent   = 1;
            end
        end else begin
            s     = {1'b0, b} + {33'b0, m};
            m_bal = (s > {1'b0, {64{1'b1}}}) ? {64{1'b1}} : s[63:0];
            bstb  = 1;
        end
        check_outs(tag, 0, 0, 0, bstb, ent, fond, 0, m_bal);
    endtask

    task automatic unlock(input string tag);
        desbloqueo = 1'b1;
        step();
        desbloqueo = 1'b0;
        m_locked = 0;
        m_int    = 0;
        quiet(tag);
    endtask

    initial begin
        reset            = 1'b1;
        tarjeta_recibida = 1'b0;
        digito_stb       = 1'b0;
        digito           = '0;
        pin_correcto     = PIN;
        tipo_trans       = 1'b0;
        trans_stb        = 1'b0;
        monto            = '0;
        balance_inicial  = '0;
        desbloqueo       = 1'b0;
        step();
        step();
        quiet("reset");
        reset = 1'b0;
        step();

        // Correct PIN, withdrawal 100 from 500.
        insert();
        try_pin(PIN, "pin_ok");
        do_trans(1'b1, 32'd100, 64'd500, "retiro100");
        remove_card();

        // Three wrong PINs lock; digits ignored while locked.
        insert();
        try_pin(16'h1111, "bad1");
        try_pin(16'h2222, "bad2");
        try_pin(16'h3333, "bad3");
        send_digit(4'h1);
        send_digit(4'h2);
        step();
        quiet("locked_hold");
        unlock("unlock");
        remove_card();

        // Insufficient funds; balance output holds previous value.
        insert();
        try_pin(PIN, "pin_ok2");
        do_trans(1'b1, 32'd600, 64'd500, "retiro600");
        remove_card();
        insert();
        try_pin(PIN, "pin_ok3");
        do_trans(1'b0, 32'd1, {64{1'b1}}, "dep_sat");
        remove_card();

        // Digit-phase timeout; admin unlock outside lock has no effect.
        insert();
        try_pin(16'h9999, "bad_pre_to");
        desbloqueo = 1'b1;
        step();
        desbloqueo = 1'b0;
        send_digit(4'h1);
        send_digit(4'h2);
        for (int i = 0; i < 15; i++) step();
        quiet("to_pre");
        step();
        check_outs("to_pin", 0, 0, 0, 0, 0, 0, 1, m_bal);
        step();
        quiet("to_after");
        try_pin(16'h5555, "bad_post_to");

        // Transaction-phase timeout.
        try_pin(PIN, "pin_ok4");
        for (int i = 0; i < 15; i++) step();
        quiet("tto_pre");
        step();
        check_outs("to_trans", 0, 0, 0, 0, 0, 0, 1, m_bal);
        remove_card();

        // Card removal after the third digit aborts silently.
        insert();
        send_digit(4'h1);
        send_digit(4'h2);
        send_digit(4'h3);
        tarjeta_recibida = 1'b0;
        step();
        quiet("rm1");
        send_digit(4'h4);
        step();
        quiet("rm2");
        insert();
        try_pin(PIN, "pin_after_rm");
        do_trans(1'b0, 32'd7, 64'd10, "dep_after_rm");
        remove_card();

        // Randomized sessions.
        for (int n = 0; n < 24; n++) begin
            logic [15:0] entered;
            logic [63:0] b;
            logic [31:0] m;
            insert();
            entered = ($urandom_range(0, 9) < 6) ? PIN : 16'($urandom);
            try_pin(entered, "rnd_pin");
            if (m_locked) begin
                unlock("rnd_unlock");
            end else if (entered == PIN) begin
                case ($urandom_range(0, 2))
                    0: begin
                        b = 64'($urandom_range(0, 1000));
                        m = 32'($urandom_range(0, 1200));
                    end
                    1: begin
                        b = {32'hFFFF_FFFF, 32'($urandom)};
                        m = 32'($urandom);
                    end
                    default: begin
                        b = {32'($urandom), 32'($urandom)};
                        m = 32'($urandom);
                    end
                endcase
                do_trans(1'($urandom_range(0, 1)), m, b, "rnd_trans");
            end
            remove_card();
        end

        // Asynchronous reset while waiting for a transaction.
        insert();
        try_pin(PIN, "pin_pre_rst");
        #3;
        reset = 1'b1;
        #1;
        m_bal    = '0;
        m_int    = 0;
        m_locked = 0;
        quiet("async_rst");
        @(negedge clk);
        reset = 1'b0;
        remove_card();
        quiet("post_rst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
